// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: restoring shift-subtract, one quotient bit per cycle.
// Divide-by-zero and signed overflow take a short path that bypasses the iterations.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST    = 6'(XLEN-1);

  state_e          state_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, dvs_q, result_q;
  logic [5:0]      cnt_q;
  logic            fast_q, is_rem_q, qneg_q, rneg_q, busy_q, done_q;

  logic            op_signed, op_rem, a_neg, b_neg, div0, ovf, ge;
  logic [XLEN-1:0] a_mag, b_mag, quo_d, fin_q, fin_r, res_d;
  logic [XLEN:0]   rem_sh, rem_d;

  // Codes without bit 2 set fall back to DIVU.
  assign op_signed = func3_i[2] & ~func3_i[0];
  assign op_rem    = func3_i[2] &  func3_i[1];
  assign a_neg     = op_signed & dividend_i[XLEN-1];
  assign b_neg     = op_signed & divisor_i[XLEN-1];
  assign a_mag     = a_neg ? (~dividend_i + ONE) : dividend_i;
  assign b_mag     = b_neg ? (~divisor_i + ONE) : divisor_i;
  assign div0      = (divisor_i == '0);
  assign ovf       = op_signed & (dividend_i == INT_MIN) & (divisor_i == '1);

  always_comb begin
    rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_d  = {quo_q[XLEN-2:0], ge};
    // Short-path results are preloaded into quo/rem with the negate flags cleared.
    fin_q  = fast_q ? quo_q : quo_d;
    fin_r  = fast_q ? rem_q[XLEN-1:0] : rem_d[XLEN-1:0];
    if (is_rem_q) res_d = rneg_q ? (~fin_r + ONE) : fin_r;
    else          res_d = qneg_q ? (~fin_q + ONE) : fin_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      fast_q   <= 1'b0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            state_q  <= S_CALC;
            is_rem_q <= op_rem;
            cnt_q    <= '0;
            if (div0) begin
              fast_q <= 1'b1;
              quo_q  <= '1;
              rem_q  <= {1'b0, dividend_i};
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
              busy_q <= 1'b0;
            end else if (ovf) begin
              fast_q <= 1'b1;
              quo_q  <= INT_MIN;
              rem_q  <= '0;
              qneg_q <= 1'b0;
              rneg_q <= 1'b0;
              busy_q <= 1'b0;
            end else begin
              fast_q <= 1'b0;
              quo_q  <= a_mag;
              dvs_q  <= b_mag;
              rem_q  <= '0;
              qneg_q <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              busy_q <= 1'b1;
            end
          end
          // The short path still spends one (non-busy) cycle here so both paths load RESULT alike.
          S_CALC: begin
            if (!fast_q) begin
              rem_q <= rem_d;
              quo_q <= quo_d;
              cnt_q <= cnt_q + 6'd1;
            end
            if (fast_q || cnt_q == LAST) begin
              state_q  <= S_DONE;
              result_q <= res_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
endmodule
